jt49_mix3: RTL
==============

JT49_MIX3 -- requirements
Module: jt49_mix3

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 cen  input  1  clock enable; the FSM advances only on clk edges with cen=1.
REQ-004 tone  input  3  square-wave bits per channel; bit0=A, bit1=B, bit2=C.
REQ-005 noise  input  1  LFSR noise bit from the noise generator stage.
REQ-006 mix_dis  input  6  mixer register, active-high disable; [2:0] tone disable A/B/C, [5:3] noise disable A/B/C.
REQ-007 amp_a, amp_b, amp_c  input  5  each: bit4=1 selects envelope; [3:0] fixed level.
REQ-008 env  input  5  envelope level, 0..31.
REQ-009 ch_a, ch_b, ch_c  output  8  per-channel linear volume, registered.
REQ-010 sound  output  10  sum of the three channels, registered.
REQ-011 sample  output  1  one-clk pulse when outputs update.

Function
REQ-012 FSM states SNAP->CA->CB->CC->SNAP; one transition per cen=1 edge; no transition when cen=0.
REQ-013 SNAP (cen=1): capture tone, noise, mix_dis, amp_a/b/c and env into snapshot registers; later states use only the snapshot.
REQ-014 Gate per channel x: on_x = (tone_x | tone_dis_x) & (noise | noise_dis_x); both disabled -> on_x=1.
REQ-015 Level per channel: amp[4]=1 -> env; amp[4]=0 and amp[3:0]=0 -> 0; otherwise {amp[3:0],1'b1}.
REQ-016 Volume val_x = on_x ? TAB[level_x] : 0; TAB has 32 entries, 8-bit: TAB[0]=0; TAB[n]=round(255*10^(-1.5*(31-n)/20)) for n>=1 (TAB[31]=255, TAB[30]=215, TAB[29]=181, TAB[1]=1).
REQ-017 CA: acc<=val_a, hold_a<=val_a. CB: acc<=acc+val_b, hold_b<=val_b.
REQ-018 CC: sound<=acc+val_c; ch_a<=hold_a, ch_b<=hold_b, ch_c<=val_c, all on the same edge; sample=1 for that clk only.
REQ-019 Arithmetic unsigned, 10 bits; maximum 765, no overflow or saturation required.
REQ-020 Latency: outputs update on the 3rd cen after the SNAP cen; update period is 4 cen.
REQ-021 Input changes after SNAP do not affect the current frame, including env changes between CA and CC.
REQ-022 cen low for any number of clks freezes state, acc and outputs; sample stays 0.

Reset
REQ-023 rst_n=0 immediately forces state=SNAP, acc=0, snapshot=0, ch_a/b/c=0, sound=0, sample=0.
REQ-024 Reset asserted mid-frame discards the partial frame; the first cen after release is a SNAP.

Structure
REQ-025 State encoding constants (SNAP, CA, CB, CC) and the TAB width (8) belong in the shared jt49 package.
REQ-026 TAB is a purely combinational sub-module, jt49_voltab (5-bit in, 8-bit out); it is shared by the three channels through time multiplexing (one instance).

Verification
REQ-027 All mix_dis=6'h3F, amp_a=amp_b=amp_c=5'h0F, cen always 1 -> ch_a=ch_b=ch_c=255, sound=765, sample every 4th clk.
REQ-028 mix_dis=0, tone=3'b000, noise=1, amp_a=5'h0F -> ch_a=0, sound=0; then tone=3'b001 -> ch_a=255.
REQ-029 amp_b=5'h10, env=30, mix_dis=6'h3F, others 0 -> ch_b=215, sound=215; env changed to 31 between CA and CC -> unchanged until the next frame (then 255).
REQ-030 cen pulsed every 3rd clk -> one output update per 12 clks; outputs stable between updates.
REQ-031 rst_n asserted during CB -> all outputs 0 at once; after release, first valid frame appears 4 cen later.
REQ-032 amp_c=5'h01 (level 3) and 5'h00, mix_dis=6'h3F -> ch_c=TAB[3] and 0 respectively.

Source files
------------

// File: rtl/jt49_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jt49_pkg
//  Purpose  : Shared definitions for the jt49 three-channel mixer: mixer FSM
//             state encoding, volume table width, accumulator width, the
//             input snapshot record and the amplitude-to-level helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package jt49_pkg;

  localparam int TAB_W = 8;   // width of one volume table entry
  localparam int SUM_W = 10;  // three 8-bit channels summed (max 765)

  typedef enum logic [1:0] {
    SNAP = 2'd0,
    CA   = 2'd1,
    CB   = 2'd2,
    CC   = 2'd3
  } mix_state_t;

  // Everything a frame needs, frozen at the SNAP step.
  typedef struct packed {
    logic [2:0] tone;
    logic       noise;
    logic [5:0] mix_dis;
    logic [4:0] amp_a;
    logic [4:0] amp_b;
    logic [4:0] amp_c;
    logic [4:0] env;
  } snap_t;

  // Map a channel amplitude register onto a 5-bit table index. Fixed levels
  // sit on the odd entries so that fixed level 15 lands on the table top.
  function automatic logic [4:0] level_of(input logic [4:0] amp,
                                          input logic [4:0] env);
    logic [4:0] lvl;
    if (amp[4])
      lvl = env;
    else if (amp[3:0] == 4'd0)
      lvl = 5'd0;
    else
      lvl = {amp[3:0], 1'b1};
    return lvl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jt49_voltab.sv
`default_nettype none
// ============================================================================
//  Module   : jt49_voltab
//  Purpose  : Logarithmic volume table, 1.5 dB per step, 32 entries.
//             Purely combinational.
//  Ports    : i_level [4:0]        table index (0 = silence)
//             o_vol   [TAB_W-1:0]  linear volume, 0..255
//  Revision : 1.0 - initial release
// ============================================================================
module jt49_voltab
  import jt49_pkg::*;
(
  input  logic [4:0]       i_level,
  output logic [TAB_W-1:0] o_vol
);

  always_comb begin
    o_vol = '0;
    case (i_level)
      5'd0 : o_vol = 8'd0;
      5'd1 : o_vol = 8'd1;
      5'd2 : o_vol = 8'd2;
      5'd3 : o_vol = 8'd2;
      5'd4 : o_vol = 8'd2;
      5'd5 : o_vol = 8'd3;
      5'd6 : o_vol = 8'd3;
      5'd7 : o_vol = 8'd4;
      5'd8 : o_vol = 8'd5;
      5'd9 : o_vol = 8'd6;
      5'd10: o_vol = 8'd7;
      5'd11: o_vol = 8'd8;
      5'd12: o_vol = 8'd10;
      5'd13: o_vol = 8'd11;
      5'd14: o_vol = 8'd14;
      5'd15: o_vol = 8'd16;
      5'd16: o_vol = 8'd19;
      5'd17: o_vol = 8'd23;
      5'd18: o_vol = 8'd27;
      5'd19: o_vol = 8'd32;
      5'd20: o_vol = 8'd38;
      5'd21: o_vol = 8'd45;
      5'd22: o_vol = 8'd54;
      5'd23: o_vol = 8'd64;
      5'd24: o_vol = 8'd76;
      5'd25: o_vol = 8'd90;
      5'd26: o_vol = 8'd108;
      5'd27: o_vol = 8'd128;
      5'd28: o_vol = 8'd152;
      5'd29: o_vol = 8'd181;
      5'd30: o_vol = 8'd215;
      5'd31: o_vol = 8'd255;
      default: o_vol = 8'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/jt49_mix3.sv
`default_nettype none
// ============================================================================
//  Module   : jt49_mix3
//  Purpose  : Three-channel gate/volume/mix stage. A four-step frame
//             (SNAP, CA, CB, CC) freezes the inputs, then evaluates one
//             channel per clock-enable through a single shared volume table,
//             accumulating the sum. All outputs update together at CC.
//  Ports    : clk, rst_n (async, active low), cen (clock enable)
//             tone[2:0] A/B/C square bits, noise LFSR bit
//             mix_dis[5:0] {noise dis C..A, tone dis C..A}
//             amp_a/b/c[4:0] {env select, fixed level}, env[4:0]
//             ch_a/b/c[7:0] channel volumes, sound[9:0] sum,
//             sample one-clk pulse on output update
//  Revision : 1.0 - initial release
// ============================================================================
module jt49_mix3
  import jt49_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic [2:0]       tone,
  input  logic             noise,
  input  logic [5:0]       mix_dis,
  input  logic [4:0]       amp_a,
  input  logic [4:0]       amp_b,
  input  logic [4:0]       amp_c,
  input  logic [4:0]       env,
  output logic [TAB_W-1:0] ch_a,
  output logic [TAB_W-1:0] ch_b,
  output logic [TAB_W-1:0] ch_c,
  output logic [SUM_W-1:0] sound,
  output logic             sample
);

  mix_state_t       r_state;
  snap_t            r_snap;
  logic [SUM_W-1:0] r_acc;
  logic [TAB_W-1:0] r_hold_a;
  logic [TAB_W-1:0] r_hold_b;

  logic [4:0]       w_amp;
  logic             w_tone;
  logic             w_tone_dis;
  logic             w_noise_dis;
  logic             w_on;
  logic [4:0]       w_level;
  logic [TAB_W-1:0] w_tab;
  logic [TAB_W-1:0] w_val;
  logic [SUM_W-1:0] w_val_ext;

  // Channel currently being evaluated follows the state; SNAP's selection is
  // unused, so it shares channel A's path.
  always_comb begin
    w_amp       = r_snap.amp_a;
    w_tone      = r_snap.tone[0];
    w_tone_dis  = r_snap.mix_dis[0];
    w_noise_dis = r_snap.mix_dis[3];
    case (r_state)
      CB: begin
        w_amp       = r_snap.amp_b;
        w_tone      = r_snap.tone[1];
        w_tone_dis  = r_snap.mix_dis[1];
        w_noise_dis = r_snap.mix_dis[4];
      end
      CC: begin
        w_amp       = r_snap.amp_c;
        w_tone      = r_snap.tone[2];
        w_tone_dis  = r_snap.mix_dis[2];
        w_noise_dis = r_snap.mix_dis[5];
      end
      default: ;
    endcase
  end

  // A disabled source counts as permanently high, so with both disabled the
  // channel is always on and outputs its level as a DC value.
  assign w_on      = (w_tone | w_tone_dis) & (r_snap.noise | w_noise_dis);
  assign w_level   = level_of(w_amp, r_snap.env);
  assign w_val     = w_on ? w_tab : '0;
  assign w_val_ext = {{(SUM_W-TAB_W){1'b0}}, w_val};

  jt49_voltab u_voltab (
    .i_level (w_level),
    .o_vol   (w_tab)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= SNAP;
      r_snap   <= '0;
      r_acc    <= '0;
      r_hold_a <= '0;
      r_hold_b <= '0;
      ch_a     <= '0;
      ch_b     <= '0;
      ch_c     <= '0;
      sound    <= '0;
      sample   <= 1'b0;
    end else begin
      sample <= 1'b0;
      if (cen) begin
        case (r_state)
          SNAP: begin
            r_snap.tone    <= tone;
            r_snap.noise   <= noise;
            r_snap.mix_dis <= mix_dis;
            r_snap.amp_a   <= amp_a;
            r_snap.amp_b   <= amp_b;
            r_snap.amp_c   <= amp_c;
            r_snap.env     <= env;
            r_state        <= CA;
          end
          CA: begin
            r_acc    <= w_val_ext;
            r_hold_a <= w_val;
            r_state  <= CB;
          end
          CB: begin
            r_acc    <= r_acc + w_val_ext;
            r_hold_b <= w_val;
            r_state  <= CC;
          end
          CC: begin
            sound   <= r_acc + w_val_ext;
            ch_a    <= r_hold_a;
            ch_b    <= r_hold_b;
            ch_c    <= w_val;
            sample  <= 1'b1;
            r_state <= SNAP;
          end
          default: r_state <= SNAP;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
